// File: rtl/fifo_word_serializer_pkg.sv
// ----------------------------------------------------------------------------
// fifo_word_serializer_pkg
// Shared definitions for the FIFO word serializer:
//   - state_t    : FSM state encoding (IDLE=0, FETCH=1, SEND=2)
//   - widths_ok(): elaboration-time check that a word splits into whole beats
// No ports (package).
// ----------------------------------------------------------------------------
package fifo_word_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  // True when a word of width w divides into an integer number (>= 1) of
  // beats of width b.
  function automatic bit widths_ok(input int unsigned w, input int unsigned b);
    return (b != 0) && (w >= b) && ((w % b) == 0);
  endfunction

endpackage

// File: rtl/fifo_word_serializer_if.sv
// ----------------------------------------------------------------------------
// fifo_word_serializer_if
// Groups the FIFO read port and the byte-wide output stream of the serializer.
//   fifo_empty      FIFO empty flag            (FIFO -> serializer)
//   fifo_rd_en      FIFO pop request           (serializer -> FIFO)
//   fifo_dout       FIFO read data, valid the cycle after a pop
//   data_out        current beat               (serializer -> sink)
//   data_out_valid  beat valid                 (serializer -> sink)
//   data_out_ready  sink accepts the beat      (sink -> serializer)
// Modports: master = serializer side, slave = FIFO/sink side.
// ----------------------------------------------------------------------------
interface fifo_word_serializer_if #(
  parameter int WORD_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [WORD_WIDTH-1:0] fifo_dout;
  logic [BYTE_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;

  modport master (
    input  fifo_empty, fifo_dout, data_out_ready,
    output fifo_rd_en, data_out, data_out_valid
  );

  modport slave (
    output fifo_empty, fifo_dout, data_out_ready,
    input  fifo_rd_en, data_out, data_out_valid
  );
endinterface

// File: rtl/fifo_word_serializer.sv
// ----------------------------------------------------------------------------
// fifo_word_serializer
// Pops WORD_WIDTH-bit words from a FIFO read port and emits them LSB-first as
// BYTE_WIDTH-bit beats on a valid/ready stream.
//
// Ports:
//   clk, rst       single clock; synchronous active-high reset
//   bus            fifo_word_serializer_if.master (FIFO read port + stream)
//   busy           high whenever the FSM is not in IDLE
//   o_dbg_state    current FSM state
//   words_sent,    32-bit wrapping counters, only present when the macro
//   bytes_sent     SERIALIZER_STATS_EN is defined
//
// Stream handshake: a beat transfers (fires) on a rising clk edge where
// data_out_valid && data_out_ready. Once data_out_valid is raised it stays
// high, and data_out stays unchanged, until that beat fires; the sink may
// hold data_out_ready at any level and must not derive it combinationally
// from fifo_rd_en.
//
// FIFO side: fifo_rd_en is a combinational pop request, never raised while
// fifo_empty=1; the popped word is taken from fifo_dout one cycle later
// (FETCH state). Only one word is in flight at a time.
// ----------------------------------------------------------------------------
module fifo_word_serializer
  import fifo_word_serializer_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_word_serializer_if.master bus,
  output logic                   busy,
  output state_t                 o_dbg_state
`ifdef SERIALIZER_STATS_EN
  ,
  output logic [31:0]            words_sent,
  output logic [31:0]            bytes_sent
`endif
);

  localparam int NBYTES = WORD_WIDTH / BYTE_WIDTH;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  if (!widths_ok(WORD_WIDTH, BYTE_WIDTH)) begin : g_bad_widths
    $error("fifo_word_serializer: WORD_WIDTH must be a positive multiple of BYTE_WIDTH");
  end

  state_t                r_state;
  state_t                w_next;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_rst_d;   // high for the first cycle after reset
  logic                  w_fire;
  logic                  w_last;
  logic                  w_pop;

  assign w_fire = (r_state == ST_SEND) && bus.data_out_ready;
  assign w_last = (r_idx == IDX_W'(NBYTES - 1));

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // No pop in the cycle right after reset, so a word left in the FIFO
        // is only taken once the block has settled in IDLE.
        if (!bus.fifo_empty && !r_rst_d) begin
          w_pop  = 1'b1;
          w_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_next = ST_SEND;
      end
      ST_SEND: begin
        if (w_fire && w_last) begin
          // Back-to-back: pop the next word while the last beat leaves.
          if (!bus.fifo_empty) begin
            w_pop  = 1'b1;
            w_next = ST_FETCH;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    if (rst) begin
      w_pop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_rst_d <= 1'b1;
    end else begin
      r_state <= w_next;
      r_rst_d <= 1'b0;
      if (r_state == ST_FETCH) begin
        r_shift <= bus.fifo_dout;
        r_idx   <= '0;
      end else if (w_fire && !w_last) begin
        r_shift <= r_shift >> BYTE_WIDTH;
        r_idx   <= r_idx + IDX_W'(1);
      end
    end
  end

  assign bus.fifo_rd_en     = w_pop;
  assign bus.data_out       = r_shift[BYTE_WIDTH-1:0];
  assign bus.data_out_valid = (r_state == ST_SEND);
  assign busy               = (r_state != ST_IDLE);
  assign o_dbg_state        = r_state;

`ifdef SERIALIZER_STATS_EN
  logic [31:0] r_words_sent;
  logic [31:0] r_bytes_sent;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_words_sent <= '0;
      r_bytes_sent <= '0;
    end else begin
      if (w_fire) begin
        r_bytes_sent <= r_bytes_sent + 32'd1;
      end
      if (w_fire && w_last) begin
        r_words_sent <= r_words_sent + 32'd1;
      end
    end
  end

  assign words_sent = r_words_sent;
  assign bytes_sent = r_bytes_sent;
`endif

endmodule

// File: tb/tb_fifo_word_serializer.sv
// ----------------------------------------------------------------------------
// tb_fifo_word_serializer
// Directed bench for fifo_word_serializer (32-bit words, 8-bit beats) with a
// small behavioural FIFO as the upstream source and a byte scoreboard.
// Optional counters checked when SERIALIZER_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_fifo_word_serializer;
  import fifo_word_serializer_pkg::*;

  localparam int WW = 32;
  localparam int BW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  fifo_word_serializer_if #(.WORD_WIDTH(WW), .BYTE_WIDTH(BW)) u_if ();

  logic   busy;
  state_t dbg_state;
`ifdef SERIALIZER_STATS_EN
  logic [31:0] words_sent;
  logic [31:0] bytes_sent;
`endif

  fifo_word_serializer #(.WORD_WIDTH(WW), .BYTE_WIDTH(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (u_if.master),
    .busy        (busy),
    .o_dbg_state (dbg_state)
`ifdef SERIALIZER_STATS_EN
    ,
    .words_sent  (words_sent),
    .bytes_sent  (bytes_sent)
`endif
  );

  // ---------------- upstream FIFO model ----------------
  logic [WW-1:0] push_q[$];      // words handed over by the driver
  logic [WW-1:0] mem[$];         // FIFO contents
  logic          fifo_empty_r = 1'b1;
  logic [WW-1:0] fifo_dout_r  = '0;
  logic          ready = 1'b1;
  int            underflow = 0;

  assign u_if.fifo_empty     = fifo_empty_r;
  assign u_if.fifo_dout      = fifo_dout_r;
  assign u_if.data_out_ready = ready;

  always @(posedge clk) begin
    if (u_if.fifo_rd_en === 1'b1) begin
      if (mem.size() == 0) underflow++;
      else fifo_dout_r <= mem.pop_front();
    end
    while (push_q.size() > 0) mem.push_back(push_q.pop_front());
    fifo_empty_r <= (mem.size() == 0);
  end

  // ---------------- scoreboard / counters ----------------
  logic [BW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int fire_cnt = 0, pop_cnt = 0, bad_pop = 0, bubble_cnt = 0;
  int first_valid = -1, last_fire = -1, empty_fall = -1;
  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1, prev_empty = 1'b1;
  logic [BW-1:0] prev_data = '0;

  // ---------------- monitor (samples at negedge) ----------------
  always @(negedge clk) begin
    if (prev_valid && !prev_ready && !prev_rst) begin
      check("hold_valid", 32'(u_if.data_out_valid), 32'd1);
      check("hold_data", 32'(u_if.data_out), 32'(prev_data));
    end
    if (u_if.data_out_valid && u_if.data_out_ready) begin
      fire_cnt++;
      last_fire = cyc;
      if (exp_q.size() == 0) check("extra_beat", 32'(exp_q.size()), 32'd1);
      else check("beat", 32'(u_if.data_out), 32'(exp_q.pop_front()));
    end
    if (u_if.data_out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (prev_empty && !u_if.fifo_empty && !busy && empty_fall < 0) empty_fall = cyc;
    if (u_if.fifo_rd_en === 1'b1) pop_cnt++;
    if (u_if.fifo_rd_en === 1'b1 && u_if.fifo_empty === 1'b1) bad_pop++;
    if (dbg_state == ST_FETCH && first_valid >= 0) bubble_cnt++;
    prev_valid = u_if.data_out_valid;
    prev_ready = u_if.data_out_ready;
    prev_data  = u_if.data_out;
    prev_rst   = rst;
    prev_empty = u_if.fifo_empty;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    fire_cnt = 0; pop_cnt = 0; bubble_cnt = 0;
    first_valid = -1; last_fire = -1; empty_fall = -1;
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    push_q.push_back(w);
    for (int b = 0; b < WW / BW; b++) exp_q.push_back(w[b*BW +: BW]);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Run until scoreboard, FIFO and DUT are all idle; toggle=1 drives the
  // ready pattern 1,0,0,1,0,0,...
  task automatic drain(input string tag, input bit toggle, input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      ready = toggle ? (i % 3 == 0) : 1'b1;
      step();
      if (exp_q.size() == 0 && push_q.size() == 0 && mem.size() == 0 && !busy) done = 1'b1;
    end
    ready = 1'b1;
    check(tag, 32'(done), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_rd, n_val, n_busy;

    // Reset state
    step(); step();
    @(negedge clk);
    check("rst_valid", 32'(u_if.data_out_valid), 32'd0);
    check("rst_data", 32'(u_if.data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(u_if.fifo_rd_en), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    rst = 1'b0;
    step(); step();

    // 1. Single word, ready held high
    clear_stats();
    push_word(32'h11223344);
    drain("s1_drain", 1'b0, 40);
    @(negedge clk);
    check("s1_latency", 32'(first_valid - empty_fall), 32'd2);
    check("s1_consecutive", 32'(last_fire - first_valid), 32'd3);
    check("s1_beats", 32'(fire_cnt), 32'd4);
    check("s1_pops", 32'(pop_cnt), 32'd1);
    check("s1_busy", 32'(busy), 32'd0);
    check("s1_valid", 32'(u_if.data_out_valid), 32'd0);
    step();

    // 2. Backpressure
    clear_stats();
    push_word(32'h11223344);
    drain("s2_drain", 1'b1, 80);
    @(negedge clk);
    check("s2_beats", 32'(fire_cnt), 32'd4);
    check("s2_pops", 32'(pop_cnt), 32'd1);
    check("s2_busy", 32'(busy), 32'd0);
    step();

    // 3. Back-to-back, 8 preloaded words
    pulse_reset();
    step(); step();
    clear_stats();
    for (int i = 0; i < 8; i++) push_word(32'd1000 + 32'(i));
    drain("s3_drain", 1'b0, 100);
    @(negedge clk);
    check("s3_latency", 32'(first_valid - empty_fall), 32'd2);
    check("s3_span", 32'(last_fire - first_valid + 1), 32'd39);
    check("s3_bubbles", 32'(bubble_cnt), 32'd7);
    check("s3_beats", 32'(fire_cnt), 32'd32);
    check("s3_pops", 32'(pop_cnt), 32'd8);
    check("s3_fifo_empty", 32'(u_if.fifo_empty), 32'd1);
`ifdef SERIALIZER_STATS_EN
    // 6. Statistics counters
    check("s6_bytes", bytes_sent, 32'd32);
    check("s6_words", words_sent, 32'd8);
    step();
    pulse_reset();
    @(negedge clk);
    check("s6_bytes_rst", bytes_sent, 32'd0);
    check("s6_words_rst", words_sent, 32'd0);
`endif
    step();

    // 4. Empty FIFO for 20 cycles
    n_rd = 0; n_val = 0; n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.fifo_rd_en !== 1'b0) n_rd++;
      if (u_if.data_out_valid !== 1'b0) n_val++;
      if (busy !== 1'b0) n_busy++;
      step();
    end
    check("s4_rd_en", 32'(n_rd), 32'd0);
    check("s4_valid", 32'(n_val), 32'd0);
    check("s4_busy", 32'(n_busy), 32'd0);

    // 5. Reset after two beats, second word queued
    clear_stats();
    push_word(32'hAABBCCDD);
    push_word(32'h01020304);
    for (int i = 0; i < 30 && fire_cnt < 2; i++) step();
    check("s5_two_beats", 32'(fire_cnt), 32'd2);
    ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(4 - b));
    step();
    rst = 1'b0;
    ready = 1'b1;
    clear_stats();
    @(negedge clk);
    check("s5_valid_after_rst", 32'(u_if.data_out_valid), 32'd0);
    check("s5_rd_en_after_rst", 32'(u_if.fifo_rd_en), 32'd0);
    check("s5_data_after_rst", 32'(u_if.data_out), 32'd0);
    drain("s5_drain", 1'b0, 40);
    @(negedge clk);
    check("s5_beats", 32'(fire_cnt), 32'd4);
    check("s5_pops", 32'(pop_cnt), 32'd1);

    // Global protocol checks
    check("pop_while_empty", 32'(bad_pop), 32'd0);
    check("fifo_underflow", 32'(underflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
